// File: rtl/multicycle_controller_if.sv
// Control/status bundle between multicycle_controller (master) and the 8-bit datapath (slave).
interface multicycle_controller_if;
  logic [3:0] IrToCU;
  logic [4:0] DiToCU;
  logic [2:0] CznToCU;
  logic       pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
  logic       aRegWriteEn, bRegWriteEn, aluResWriteEn, accumulatorWriteEn, ldCZN;
  logic       memoryReadEn, memoryWriteEn;
  logic       PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0;
  logic [1:0] aluOpControl;
  logic       halted;

  modport master (
    input  IrToCU, DiToCU, CznToCU,
    output pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn,
    output aRegWriteEn, bRegWriteEn, aluResWriteEn, accumulatorWriteEn, ldCZN,
    output memoryReadEn, memoryWriteEn,
    output PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0, aluOpControl, halted
  );

  modport slave (
    output IrToCU, DiToCU, CznToCU,
    input  pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn,
    input  aRegWriteEn, bRegWriteEn, aluResWriteEn, accumulatorWriteEn, ldCZN,
    input  memoryReadEn, memoryWriteEn,
    input  PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0, aluOpControl, halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 8-bit multi-cycle CPU datapath.
// Define CTRL_LDA_FLAGS_EN to make LDA update the C/Z/N flags as well.
module multicycle_controller (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] ADDR   = 4'd2;
  localparam logic [3:0] LD_MEM = 4'd3;
  localparam logic [3:0] LD_ALU = 4'd4;
  localparam logic [3:0] ST_A   = 4'd5;
  localparam logic [3:0] ST_ALU = 4'd6;
  localparam logic [3:0] ST_MEM = 4'd7;
  localparam logic [3:0] JUMP   = 4'd8;
  localparam logic [3:0] RR_A   = 4'd9;
  localparam logic [3:0] RR_B   = 4'd10;
  localparam logic [3:0] RR_ALU = 4'd11;
  localparam logic [3:0] WB     = 4'd12;
  localparam logic [3:0] HALT   = 4'd13;

  logic [3:0] state, nextState;
  logic [2:0] op;
  logic       isRegOp, zFlag, cFlag;

  assign op      = bus.IrToCU[3:1];
  assign isRegOp = (bus.IrToCU[3:2] == 2'b11);
  assign zFlag   = bus.CznToCU[1];
  assign cFlag   = bus.CznToCU[0];

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        if (isRegOp)            nextState = RR_A;
        else if (op == 3'b101)  nextState = HALT;
        else                    nextState = ADDR;
      end
      ADDR: begin
        case (op)
          3'b000:  nextState = LD_MEM;
          3'b001:  nextState = ST_A;
          3'b010:  nextState = JUMP;
          3'b011:  nextState = zFlag ? JUMP : FETCH;
          3'b100:  nextState = cFlag ? JUMP : FETCH;
          default: nextState = FETCH;
        endcase
      end
      LD_MEM: nextState = LD_ALU;
      LD_ALU: nextState = WB;
      ST_A:   nextState = ST_ALU;
      ST_ALU: nextState = ST_MEM;
      ST_MEM: nextState = FETCH;
      JUMP:   nextState = FETCH;
      RR_A:   nextState = RR_B;
      RR_B:   nextState = RR_ALU;
      RR_ALU: nextState = WB;
      WB:     nextState = FETCH;
      HALT:   nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  // Outputs are forced low while rst is high, independent of the current state.
  always_comb begin
    bus.pcInc              = 1'b0;
    bus.pcLoadEn           = 1'b0;
    bus.diLoadEn           = 1'b0;
    bus.irWriteEn          = 1'b0;
    bus.trWriteEn          = 1'b0;
    bus.aRegWriteEn        = 1'b0;
    bus.bRegWriteEn        = 1'b0;
    bus.aluResWriteEn      = 1'b0;
    bus.accumulatorWriteEn = 1'b0;
    bus.ldCZN              = 1'b0;
    bus.memoryReadEn       = 1'b0;
    bus.memoryWriteEn      = 1'b0;
    bus.PcOrTR             = 1'b0;
    bus.reg1Or2            = 1'b0;
    bus.regOrMem           = 1'b0;
    bus.RegBOr0            = 1'b0;
    bus.RegAOr0            = 1'b0;
    bus.aluOpControl       = '0;
    bus.halted             = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.PcOrTR       = 1'b1;
          bus.memoryReadEn = 1'b1;
          bus.irWriteEn    = 1'b1;
          bus.pcInc        = 1'b1;
        end
        DECODE: bus.diLoadEn = 1'b1;
        ADDR: begin
          bus.PcOrTR       = 1'b1;
          bus.memoryReadEn = 1'b1;
          bus.trWriteEn    = 1'b1;
          bus.pcInc        = 1'b1;
        end
        LD_MEM: begin
          bus.memoryReadEn = 1'b1;
          bus.bRegWriteEn  = 1'b1;
        end
        LD_ALU: begin
          bus.RegAOr0       = 1'b1;
          bus.aluResWriteEn = 1'b1;
`ifdef CTRL_LDA_FLAGS_EN
          bus.ldCZN         = 1'b1;
`else
          bus.ldCZN         = 1'b0;
`endif
        end
        ST_A:   bus.aRegWriteEn = 1'b1;
        ST_ALU: begin
          bus.RegBOr0       = 1'b1;
          bus.aluResWriteEn = 1'b1;
        end
        ST_MEM: bus.memoryWriteEn = 1'b1;
        JUMP:   bus.pcLoadEn = 1'b1;
        RR_A:   bus.aRegWriteEn = 1'b1;
        RR_B: begin
          bus.reg1Or2     = 1'b1;
          bus.regOrMem    = 1'b1;
          bus.bRegWriteEn = 1'b1;
        end
        RR_ALU: begin
          bus.aluOpControl  = bus.IrToCU[1:0];
          bus.aluResWriteEn = 1'b1;
          bus.ldCZN         = 1'b1;
        end
        WB: begin
          bus.accumulatorWriteEn = 1'b1;
          bus.reg1Or2            = isRegOp;
        end
        HALT:   bus.halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Closed-loop bench: a behavioural datapath runs small programs while a per-cycle
// scoreboard of expected control words is checked against the controller.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
    logic aRegWriteEn, bRegWriteEn, aluResWriteEn, accumulatorWriteEn, ldCZN;
    logic memoryReadEn, memoryWriteEn;
    logic PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0;
    logic [1:0] aluOp;
    logic halted;
  } ctl_t;

  localparam int S_FETCH = 0, S_DECODE = 1, S_ADDR = 2, S_LD_MEM = 3, S_LD_ALU = 4;
  localparam int S_ST_A = 5, S_ST_ALU = 6, S_ST_MEM = 7, S_JUMP = 8, S_RR_A = 9;
  localparam int S_RR_B = 10, S_RR_ALU = 11, S_WB = 12, S_HALT = 13;

  // Behavioural datapath state
  logic [7:0]  mem [0:8191];
  logic [7:0]  rf  [0:3];
  logic [12:0] pc, tr;
  logic [7:0]  ir, a, b, res;
  logic [4:0]  di;
  logic [2:0]  czn;
  int unsigned wrCount;

  assign bus.IrToCU  = ir[7:4];
  assign bus.DiToCU  = di;
  assign bus.CznToCU = czn;

  ctl_t expQ [$];
  int nChecks = 0;
  int nFail   = 0;

  function automatic ctl_t word(input int st, input logic [1:0] aop, input logic r);
    ctl_t w;
    w = '0;
    case (st)
      S_FETCH:  begin w.PcOrTR = 1; w.memoryReadEn = 1; w.irWriteEn = 1; w.pcInc = 1; end
      S_DECODE: w.diLoadEn = 1;
      S_ADDR:   begin w.PcOrTR = 1; w.memoryReadEn = 1; w.trWriteEn = 1; w.pcInc = 1; end
      S_LD_MEM: begin w.memoryReadEn = 1; w.bRegWriteEn = 1; end
      S_LD_ALU: begin
        w.RegAOr0 = 1; w.aluResWriteEn = 1;
`ifdef CTRL_LDA_FLAGS_EN
        w.ldCZN = 1;
`endif
      end
      S_ST_A:   w.aRegWriteEn = 1;
      S_ST_ALU: begin w.RegBOr0 = 1; w.aluResWriteEn = 1; end
      S_ST_MEM: w.memoryWriteEn = 1;
      S_JUMP:   w.pcLoadEn = 1;
      S_RR_A:   w.aRegWriteEn = 1;
      S_RR_B:   begin w.reg1Or2 = 1; w.regOrMem = 1; w.bRegWriteEn = 1; end
      S_RR_ALU: begin w.aluOp = aop; w.aluResWriteEn = 1; w.ldCZN = 1; end
      S_WB:     begin w.accumulatorWriteEn = 1; w.reg1Or2 = r; end
      S_HALT:   w.halted = 1;
      default:  ;
    endcase
    return w;
  endfunction

  // Expected control sequence for one instruction, from the ISA description.
  task automatic pushInstr(input logic [7:0] i8);
    logic [2:0] op;
    op = i8[7:5];
    expQ.push_back(word(S_FETCH, 2'b00, 1'b0));
    expQ.push_back(word(S_DECODE, 2'b00, 1'b0));
    if (i8[7:6] == 2'b11) begin
      expQ.push_back(word(S_RR_A, 2'b00, 1'b0));
      expQ.push_back(word(S_RR_B, 2'b00, 1'b0));
      expQ.push_back(word(S_RR_ALU, i8[5:4], 1'b0));
      expQ.push_back(word(S_WB, 2'b00, 1'b1));
    end else if (op != 3'b101) begin
      expQ.push_back(word(S_ADDR, 2'b00, 1'b0));
      case (op)
        3'b000: begin
          expQ.push_back(word(S_LD_MEM, 2'b00, 1'b0));
          expQ.push_back(word(S_LD_ALU, 2'b00, 1'b0));
          expQ.push_back(word(S_WB, 2'b00, 1'b0));
        end
        3'b001: begin
          expQ.push_back(word(S_ST_A, 2'b00, 1'b0));
          expQ.push_back(word(S_ST_ALU, 2'b00, 1'b0));
          expQ.push_back(word(S_ST_MEM, 2'b00, 1'b0));
        end
        3'b010: expQ.push_back(word(S_JUMP, 2'b00, 1'b0));
        3'b011: if (czn[1]) expQ.push_back(word(S_JUMP, 2'b00, 1'b0));
        default: if (czn[0]) expQ.push_back(word(S_JUMP, 2'b00, 1'b0));
      endcase
    end
  endtask

  // Applies what the datapath does at the coming rising edge, given current controls.
  task automatic modelStep();
    logic [12:0] maddr;
    logic [7:0]  md, opA, opB, aluOut;
    logic [1:0]  ra;
    logic        carry;
    if (rst) begin
      pc = '0;
      return;
    end
    maddr = bus.PcOrTR ? pc : tr;
    md    = mem[maddr];
    ra    = bus.reg1Or2 ? bus.DiToCU[3:2] : bus.DiToCU[1:0];
    opA   = bus.RegAOr0 ? 8'h00 : a;
    opB   = bus.RegBOr0 ? 8'h00 : b;
    carry = 1'b0;
    case (bus.aluOpControl)
      2'b00:   {carry, aluOut} = {1'b0, opA} + {1'b0, opB};
      2'b01:   begin aluOut = opB - opA; carry = (opB < opA); end
      2'b10:   aluOut = opA & opB;
      default: aluOut = ~opB;
    endcase
    if (bus.memoryWriteEn) begin mem[maddr] = res; wrCount++; end
    if (bus.accumulatorWriteEn) rf[ra] = res;
    if (bus.irWriteEn)  ir = md;
    if (bus.diLoadEn)   di = ir[4:0];
    if (bus.pcLoadEn)   pc = tr;
    if (bus.trWriteEn)  tr = {di, md};
    if (bus.pcInc)      pc = pc + 13'd1;
    if (bus.aRegWriteEn) a = rf[ra];
    if (bus.bRegWriteEn) b = bus.regOrMem ? rf[ra] : md;
    if (bus.aluResWriteEn) res = aluOut;
    if (bus.ldCZN) czn = {aluOut[7], aluOut == 8'h00, carry};
  endtask

  task automatic cycle(input string name);
    ctl_t obs, exp;
    #1;
    obs = {bus.pcInc, bus.pcLoadEn, bus.diLoadEn, bus.irWriteEn, bus.trWriteEn,
           bus.aRegWriteEn, bus.bRegWriteEn, bus.aluResWriteEn, bus.accumulatorWriteEn,
           bus.ldCZN, bus.memoryReadEn, bus.memoryWriteEn, bus.PcOrTR, bus.reg1Or2,
           bus.regOrMem, bus.RegBOr0, bus.RegAOr0, bus.aluOpControl, bus.halted};
    nChecks++;
    if (expQ.size() == 0) begin
      nFail++;
      $display("FAIL %s ctl: scoreboard empty, got %h", name, obs);
    end else begin
      exp = expQ.pop_front();
      if (obs !== exp) begin
        nFail++;
        $display("FAIL %s ctl: got %h expected %h", name, obs, exp);
      end
    end
    nChecks++;
    if ((bus.pcInc && bus.pcLoadEn) || (bus.memoryReadEn && bus.memoryWriteEn)) begin
      nFail++;
      $display("FAIL %s exclusive: got ctl %h, conflicting strobes required 0", name, obs);
    end
    modelStep();
    @(negedge clk);
  endtask

  task automatic runQueue(input string name);
    for (int i = 0; i < 64 && expQ.size() > 0; i++) cycle(name);
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL %s drain: %0d left, required 0", name, expQ.size());
    end
  endtask

  task automatic runInstr(input string name);
    pushInstr(mem[pc]);
    runQueue(name);
  endtask

  task automatic chk8(input string name, input logic [12:0] got, input logic [12:0] want);
    nChecks++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    expQ.push_back('0);
    expQ.push_back('0);
    runQueue("reset");
    rst = 1'b0;
    chk8("reset_pc", pc, 13'h0);
  endtask

  task automatic test_lda();
    mem[0] = 8'h01; mem[1] = 8'h05; mem[13'h105] = 8'h3C;
    mem[2] = 8'h01; mem[3] = 8'h06; mem[13'h106] = 8'h00;
    czn = 3'b001;
    runInstr("lda1");
    chk8("lda1_r1", {5'b0, rf[1]}, 13'h3C);
    chk8("lda1_pc", pc, 13'h2);
`ifdef CTRL_LDA_FLAGS_EN
    chk8("lda1_czn", {10'b0, bus.CznToCU}, 13'h0);
`else
    chk8("lda1_czn", {10'b0, bus.CznToCU}, 13'h1);
`endif
    runInstr("lda0");
    chk8("lda0_r1", {5'b0, rf[1]}, 13'h00);
    chk8("lda0_pc", pc, 13'h4);
`ifdef CTRL_LDA_FLAGS_EN
    chk8("lda0_czn", {10'b0, bus.CznToCU}, 13'h2);
`else
    chk8("lda0_czn", {10'b0, bus.CznToCU}, 13'h1);
`endif
  endtask

  task automatic test_sub_jz();
    rf[2] = 8'h05; rf[1] = 8'h05;
    mem[4] = 8'hD9; mem[5] = 8'h60; mem[6] = 8'h40;
    runInstr("sub");
    chk8("sub_r2", {5'b0, rf[2]}, 13'h00);
    chk8("sub_z", {12'b0, bus.CznToCU[1]}, 13'h1);
    runInstr("jz_taken");
    chk8("jz_taken_pc", pc, 13'h40);
  endtask

  task automatic test_not_taken();
    czn = 3'b000;
    mem[13'h40] = 8'h60; mem[13'h41] = 8'h00;
    mem[13'h42] = 8'h80; mem[13'h43] = 8'h00;
    mem[13'h44] = 8'h40; mem[13'h45] = 8'h80;
    runInstr("jz_not");
    chk8("jz_not_pc", pc, 13'h42);
    runInstr("jc_not");
    chk8("jc_not_pc", pc, 13'h44);
    runInstr("jmp");
    chk8("jmp_pc", pc, 13'h80);
  endtask

  task automatic test_alu_jc();
    rf[0] = 8'h80; rf[1] = 8'h80; rf[2] = 8'h3C; rf[3] = 8'hF0;
    mem[13'h80] = 8'hC1; mem[13'h81] = 8'h81; mem[13'h82] = 8'h23;
    mem[13'h123] = 8'hEE; mem[13'h124] = 8'hF4;
    runInstr("add");
    chk8("add_r0", {5'b0, rf[0]}, 13'h00);
    chk8("add_czn", {10'b0, bus.CznToCU}, 13'h3);
    runInstr("jc_taken");
    chk8("jc_taken_pc", pc, 13'h123);
    runInstr("and");
    chk8("and_r3", {5'b0, rf[3]}, 13'h30);
    runInstr("not");
    chk8("not_r1", {5'b0, rf[1]}, 13'h7F);
    chk8("not_czn", {10'b0, bus.CznToCU}, 13'h0);
  endtask

  task automatic test_sta();
    int unsigned w0;
    rf[3] = 8'hA5;
    mem[13'h125] = 8'h3F; mem[13'h126] = 8'hFF;
    w0 = wrCount;
    runInstr("sta");
    chk8("sta_mem", {5'b0, mem[13'h1FFF]}, 13'hA5);
    chk8("sta_pulses", 13'(wrCount - w0), 13'h1);
    chk8("sta_pc", pc, 13'h127);
  endtask

  task automatic test_reset_mid_sta();
    int unsigned w0;
    rf[3] = 8'h5A;
    mem[13'h127] = 8'h3F; mem[13'h128] = 8'hFE; mem[13'h1FFE] = 8'h11;
    w0 = wrCount;
    pushInstr(mem[pc]);
    for (int i = 0; i < 4; i++) cycle("sta_mid");
    rst = 1'b1;
    expQ.delete();
    expQ.push_back('0);
    expQ.push_back('0);
    runQueue("sta_mid_rst");
    rst = 1'b0;
    chk8("sta_mid_mem", {5'b0, mem[13'h1FFE]}, 13'h11);
    chk8("sta_mid_pulses", 13'(wrCount - w0), 13'h0);
    chk8("sta_mid_pc", pc, 13'h0);
    runInstr("lda_after_rst");
    chk8("lda_after_rst_r1", {5'b0, rf[1]}, 13'h3C);
  endtask

  task automatic test_halt();
    mem[2] = 8'hA0;
    runInstr("hlt");
    for (int i = 0; i < 20; i++) expQ.push_back(word(S_HALT, 2'b00, 1'b0));
    runQueue("halted");
    rst = 1'b1;
    expQ.push_back('0);
    runQueue("halt_rst");
    rst = 1'b0;
    chk8("halt_rst_pc", pc, 13'h0);
    runInstr("refetch");
    chk8("refetch_pc", pc, 13'h2);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    pc = '0; tr = '0; ir = '0; di = '0; a = '0; b = '0; res = '0; czn = '0; wrCount = 0;
    test_reset();
    test_lda();
    test_sub_jz();
    test_not_taken();
    test_alu_jc();
    test_sta();
    test_reset_mid_sta();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
